// File: rtl/thiele_coproc_arbiter.sv
// thiele_coproc_arbiter
//   Shares one coprocessor service port between a logic requester and a python
//   requester. Round-robin on ties, one transaction in flight at a time, and a
//   running mu cost charged per completed transaction.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles in WAIT without svc_ack before abort (2..65535)
//   MU_COST_LOGIC   mu charged per completed logic transaction
//   MU_COST_PY      mu charged per completed python transaction
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   logic_req/logic_addr         logic requester (held until logic_ack)
//   py_req/py_code_addr          python requester (held until py_ack)
//   logic_ack/logic_data         one-cycle completion pulse + held response
//   py_ack/py_result             one-cycle completion pulse + held response
//   svc_req/svc_kind/svc_addr    coprocessor request (kind 0=logic, 1=python)
//   svc_ack/svc_data             coprocessor completion + data
//   mu_accum                     accumulated mu cost (wraps mod 2^32)
//   err_timeout/timeout_count    sticky abort flag and saturating abort count
//
// Build option
//   THIELE_COPROC_TIMEOUT_EN     enables the WAIT timeout; otherwise WAIT waits
//                                forever and err_timeout/timeout_count read 0.

module thiele_coproc_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MU_COST_LOGIC  = 1,
    parameter int unsigned MU_COST_PY     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        logic_req,
    input  logic [31:0] logic_addr,
    input  logic        py_req,
    input  logic [31:0] py_code_addr,
    output logic        logic_ack,
    output logic [31:0] logic_data,
    output logic        py_ack,
    output logic [31:0] py_result,
    output logic        svc_req,
    output logic        svc_kind,
    output logic [31:0] svc_addr,
    input  logic        svc_ack,
    input  logic [31:0] svc_data,
    output logic [31:0] mu_accum,
    output logic        err_timeout,
    output logic [15:0] timeout_count
);

    // Elaboration-time range check on the timeout length.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_t;

    state_t state;
    logic   rr_ptr;      // 1: python has priority on the next tie
    logic   abandon;     // winner let go of its request while in WAIT

`ifdef THIELE_COPROC_TIMEOUT_EN
    localparam int unsigned     CNT_W        = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      TIMEOUT_DATA = 32'hDEAD0001;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_r;
    logic [CNT_W-1:0] to_cnt_r;

    assign err_timeout   = err_r;
    assign timeout_count = to_cnt_r;
`else
    assign err_timeout   = 1'b0;
    assign timeout_count = 16'h0000;
`endif

    logic winner_req_c;
    logic grant_py_c;

    // Request line of whoever currently owns the service port.
    assign winner_req_c = svc_kind ? py_req : logic_req;
    // Python wins when it is the only requester, or on a tie when it holds priority.
    assign grant_py_c   = py_req & (~logic_req | rr_ptr);

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            svc_req    <= 1'b0;
            svc_kind   <= 1'b0;
            svc_addr   <= '0;
            logic_ack  <= 1'b0;
            py_ack     <= 1'b0;
            logic_data <= '0;
            py_result  <= '0;
            mu_accum   <= '0;
            rr_ptr     <= 1'b0;
            abandon    <= 1'b0;
`ifdef THIELE_COPROC_TIMEOUT_EN
            wait_cnt   <= '0;
            err_r      <= 1'b0;
            to_cnt_r   <= '0;
`endif
        end else begin
            logic_ack <= 1'b0;
            py_ack    <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (logic_req || py_req) begin
                        state    <= ST_WAIT;
                        svc_req  <= 1'b1;
                        svc_kind <= grant_py_c;
                        svc_addr <= grant_py_c ? py_code_addr : logic_addr;
                        rr_ptr   <= ~grant_py_c;
                        abandon  <= 1'b0;
`ifdef THIELE_COPROC_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end

                ST_WAIT: begin
                    if (!winner_req_c) begin
                        abandon <= 1'b1;
                    end
                    if (svc_ack) begin
                        svc_req <= 1'b0;
                        // An abandoned transaction still finishes downstream but is not reported.
                        if (abandon || !winner_req_c) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_RESP;
                            if (svc_kind) begin
                                py_ack    <= 1'b1;
                                py_result <= svc_data;
                                mu_accum  <= mu_accum + 32'(MU_COST_PY);
                            end else begin
                                logic_ack  <= 1'b1;
                                logic_data <= svc_data;
                                mu_accum   <= mu_accum + 32'(MU_COST_LOGIC);
                            end
                        end
                    end
`ifdef THIELE_COPROC_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        // Abort: answer with the error word, no mu charged.
                        svc_req <= 1'b0;
                        err_r   <= 1'b1;
                        if (to_cnt_r != '1) begin
                            to_cnt_r <= to_cnt_r + CNT_W'(1);
                        end
                        if (abandon || !winner_req_c) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_RESP;
                            if (svc_kind) begin
                                py_ack    <= 1'b1;
                                py_result <= TIMEOUT_DATA;
                            end else begin
                                logic_ack  <= 1'b1;
                                logic_data <= TIMEOUT_DATA;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end

                ST_RESP: begin
                    state <= ST_DRAIN;
                end

                ST_DRAIN: begin
                    // Wait for the winner to release so its held request is not re-granted.
                    if (!winner_req_c) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thiele_coproc_arbiter.sv
// Self-checking bench for thiele_coproc_arbiter: directed scenarios followed by
// randomized request patterns, checked against a transaction-level model.
module tb_thiele_coproc_arbiter;

    localparam int unsigned TO_CYC = 8;
    localparam int unsigned COST_L = 1;
    localparam int unsigned COST_P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        logic_req = 1'b0;
    logic [31:0] logic_addr = '0;
    logic        py_req = 1'b0;
    logic [31:0] py_code_addr = '0;
    logic        logic_ack;
    logic [31:0] logic_data;
    logic        py_ack;
    logic [31:0] py_result;
    logic        svc_req;
    logic        svc_kind;
    logic [31:0] svc_addr;
    logic        svc_ack = 1'b0;
    logic [31:0] svc_data = '0;
    logic [31:0] mu_accum;
    logic        err_timeout;
    logic [15:0] timeout_count;

    thiele_coproc_arbiter #(
        .TIMEOUT_CYCLES(TO_CYC),
        .MU_COST_LOGIC (COST_L),
        .MU_COST_PY    (COST_P)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .logic_req    (logic_req),
        .logic_addr   (logic_addr),
        .py_req       (py_req),
        .py_code_addr (py_code_addr),
        .logic_ack    (logic_ack),
        .logic_data   (logic_data),
        .py_ack       (py_ack),
        .py_result    (py_result),
        .svc_req      (svc_req),
        .svc_kind     (svc_kind),
        .svc_addr     (svc_addr),
        .svc_ack      (svc_ack),
        .svc_data     (svc_data),
        .mu_accum     (mu_accum),
        .err_timeout  (err_timeout),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] exp_mu;
    logic [31:0] exp_ldata;
    logic [31:0] exp_pres;
    logic        exp_rr_py;
    logic        exp_err;
    logic [15:0] exp_to;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        exp_mu    = '0;
        exp_ldata = '0;
        exp_pres  = '0;
        exp_rr_py = 1'b0;
        exp_err   = 1'b0;
        exp_to    = '0;
    endfunction

    // Tie goes to whoever was not served last; otherwise the sole requester.
    function automatic logic pick(input logic l, input logic p);
        if (l && p) return exp_rr_py;
        return p;
    endfunction

    task automatic chk_all_clear(input string tag);
        chk({tag, "_svc_req"},  32'(svc_req), 32'd0);
        chk({tag, "_acks"},     32'({logic_ack, py_ack}), 32'd0);
        chk({tag, "_svc_kind"}, 32'(svc_kind), 32'd0);
        chk({tag, "_svc_addr"}, svc_addr, 32'd0);
        chk({tag, "_ldata"},    logic_data, 32'd0);
        chk({tag, "_pres"},     py_result, 32'd0);
        chk({tag, "_mu"},       mu_accum, 32'd0);
        chk({tag, "_err"},      32'(err_timeout), 32'd0);
        chk({tag, "_tocnt"},    32'(timeout_count), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Serve one transaction of kind k whose request is already high; returns
    // in the first idle cycle afterwards with that request released.
    task automatic do_txn(input logic k, input int dly, input logic [31:0] data, input logic drop);
        int n;
        logic [31:0] exp_addr;
        n = 0;
        exp_addr = k ? py_code_addr : logic_addr;
        while (!svc_req && n < 10) begin
            step();
            n++;
        end
        chk("grant_lat", 32'(n), 32'd1);
        chk("svc_kind", 32'(svc_kind), 32'(k));
        chk("svc_addr", svc_addr, exp_addr);
        exp_rr_py = ~k;
        if (drop) begin
            if (k) py_req = 1'b0; else logic_req = 1'b0;
        end
        repeat (dly) step();
        chk("svc_req_held", 32'(svc_req), 32'd1);
        svc_ack  = 1'b1;
        svc_data = data;
        step();
        svc_ack  = 1'b0;
        svc_data = $urandom;
        chk("svc_req_drop", 32'(svc_req), 32'd0);
        if (!drop) begin
            if (k) begin
                exp_pres = data;
                exp_mu   = exp_mu + COST_P;
            end else begin
                exp_ldata = data;
                exp_mu    = exp_mu + COST_L;
            end
        end
        chk("logic_ack", 32'(logic_ack), 32'(!drop && !k));
        chk("py_ack",    32'(py_ack),    32'(!drop && k));
        chk("logic_data", logic_data, exp_ldata);
        chk("py_result",  py_result,  exp_pres);
        chk("mu_accum",   mu_accum,   exp_mu);
        if (!drop) begin
            if (k) py_req = 1'b0; else logic_req = 1'b0;
            step();
            chk("ack_one_cycle", 32'({logic_ack, py_ack}), 32'd0);
            // Stray ack outside WAIT must be ignored.
            svc_ack = 1'($urandom_range(0, 1));
            step();
            svc_ack = 1'b0;
            chk("idle_svc_req", 32'(svc_req), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) step();
        chk_all_clear("reset");
        rst_n = 1'b1;
        step();

        // Single logic request
        logic_addr = 32'h0000_0040;
        logic_req  = 1'b1;
        do_txn(1'b0, 3, 32'hABCD1234, 1'b0);
        chk("single_mu", mu_accum, 32'd1);

        // Simultaneous requests after reset: logic first, then python
        do_reset();
        logic_addr = $urandom; py_code_addr = $urandom;
        logic_req = 1'b1; py_req = 1'b1;
        do_txn(1'b0, 1, $urandom, 1'b0);
        do_txn(1'b1, 2, 32'h12345678, 1'b0);
        chk("simul_pres", py_result, 32'h12345678);
        chk("simul_mu", mu_accum, 32'd5);

        // Fairness with continuous re-raise
        do_reset();
        logic_req = 1'b1; py_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_txn(1'(i % 2), $urandom_range(0, 3), $urandom, 1'b0);
            if (i < 2) begin
                if (i % 2 == 1) py_req = 1'b1; else logic_req = 1'b1;
            end
        end
        chk("fair_mu", mu_accum, 32'd10);

        // Stray ack while idle
        svc_ack = 1'b1;
        step();
        svc_ack = 1'b0;
        chk("stray_svc_req", 32'(svc_req), 32'd0);
        chk("stray_acks", 32'({logic_ack, py_ack}), 32'd0);
        chk("stray_mu", mu_accum, exp_mu);
        logic_addr = $urandom;
        logic_req  = 1'b1;
        do_txn(1'b0, 0, $urandom, 1'b0);

`ifdef THIELE_COPROC_TIMEOUT_EN
        begin
            int n;
            do_reset();
            py_code_addr = $urandom;
            py_req = 1'b1;
            step();
            exp_rr_py = 1'b0;
            n = 0;
            while (svc_req && n < 100) begin
                step();
                n++;
            end
            exp_pres = 32'hDEAD0001;
            exp_err  = 1'b1;
            exp_to   = 16'd1;
            chk("to_cycles", 32'(n), 32'(TO_CYC));
            chk("to_py_ack", 32'(py_ack), 32'd1);
            chk("to_pres", py_result, exp_pres);
            chk("to_mu", mu_accum, exp_mu);
            chk("to_err", 32'(err_timeout), 32'(exp_err));
            chk("to_cnt", 32'(timeout_count), 32'(exp_to));
            py_req = 1'b0;
            repeat (2) step();
        end
`endif

        // Reset while a request is outstanding
        py_code_addr = $urandom;
        py_req = 1'b1;
        step();
        chk("midrst_svc_req_pre", 32'(svc_req), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        py_req = 1'b0;
        model_reset();
        chk_all_clear("midrst");
        step();
        chk("midrst_acks_after", 32'({logic_ack, py_ack}), 32'd0);
        chk("midrst_mu_after", mu_accum, 32'd0);

        // Randomized request patterns
        for (int it = 0; it < 40; it++) begin
            int txns;
            txns = 0;
            logic_addr   = $urandom;
            py_code_addr = $urandom;
            logic_req = 1'($urandom_range(0, 1));
            py_req    = 1'($urandom_range(0, 1));
            if (!logic_req && !py_req) py_req = 1'b1;
            while ((logic_req || py_req) && txns < 6) begin
                logic k;
                logic drop;
                k    = pick(logic_req, py_req);
                drop = ($urandom_range(0, 5) == 0);
                do_txn(k, $urandom_range(0, 4), $urandom, drop);
                txns++;
                if ($urandom_range(0, 2) == 0 && txns < 4) begin
                    if (k) begin
                        py_code_addr = $urandom;
                        py_req = 1'b1;
                    end else begin
                        logic_addr = $urandom;
                        logic_req = 1'b1;
                    end
                end
            end
        end

        chk("final_mu", mu_accum, exp_mu);
        chk("final_err", 32'(err_timeout), 32'(exp_err));
        chk("final_tocnt", 32'(timeout_count), 32'(exp_to));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
